// File: rtl/broadcast_bucket_filter_if.sv
// Register-block config, RX frame pulses and filter results
// shared between the RX MAC control stage and the storm limiter.
interface broadcast_bucket_filter_if;
    logic        broadcast_filter_en;
    logic [15:0] broadcast_bucket_depth;
    logic [15:0] broadcast_bucket_interval;
    logic        rx_frame_start;
    logic        broadcast_ptn;
    logic        rx_frame_end;
    logic        drop_cnt_clr;
    logic        broadcast_drop;
    logic [15:0] tokens;
    logic [15:0] drop_cnt;

    modport master (
        output broadcast_filter_en,
        output broadcast_bucket_depth,
        output broadcast_bucket_interval,
        output rx_frame_start,
        output broadcast_ptn,
        output rx_frame_end,
        output drop_cnt_clr,
        input  broadcast_drop,
        input  tokens,
        input  drop_cnt
    );

    modport slave (
        input  broadcast_filter_en,
        input  broadcast_bucket_depth,
        input  broadcast_bucket_interval,
        input  rx_frame_start,
        input  broadcast_ptn,
        input  rx_frame_end,
        input  drop_cnt_clr,
        output broadcast_drop,
        output tokens,
        output drop_cnt
    );
endinterface

// File: rtl/broadcast_bucket_filter.sv
// Broadcast storm limiter: token bucket refilled once per interval,
// flags broadcast frames that find the bucket empty for discard.
module broadcast_bucket_filter #(
    parameter int PRESCALE   = 1000,
    parameter int PRESCALE_W = 10
) (
    input  logic                       Clk,
    input  logic                       Reset,
    broadcast_bucket_filter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        PASS,
        DROP
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [15:0]           ivl_cnt;
    logic [15:0]           tok_q;
    logic [15:0]           drop_cnt_q;
    logic                  drop_q;

    logic                  en;
    logic [15:0]           depth;
    logic                  tick;
    logic                  refill;
    logic [15:0]           avail;
    logic                  classify;
    logic                  starve;

    assign en     = bus.broadcast_filter_en;
    assign depth  = bus.broadcast_bucket_depth;
    assign tick   = (pre_cnt == PRESCALE_W'(PRESCALE - 1));
    assign refill = tick &&
                    (ivl_cnt >= bus.broadcast_bucket_interval);

    // A lowered depth clamps the stored level straight away.
    always_comb begin
        avail = depth;
        if (!refill && (tok_q < depth))
            avail = tok_q;
    end

    // Start or end in the same cycle leaves the frame unclassified.
    assign classify = (state == FRAME) && bus.broadcast_ptn &&
                      !bus.rx_frame_end && !bus.rx_frame_start;
    assign starve   = classify && en && (avail == 16'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            pre_cnt <= '0;
        else if (tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            ivl_cnt <= '0;
        else if (refill)
            ivl_cnt <= '0;
        else if (tick)
            ivl_cnt <= ivl_cnt + 16'd1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            tok_q <= '0;
        else if (!en)
            tok_q <= depth;
        else if (classify && (avail != 16'd0))
            tok_q <= avail - 16'd1;
        else
            tok_q <= avail;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            drop_cnt_q <= '0;
        else if (bus.drop_cnt_clr)
            drop_cnt_q <= '0;
        else if (starve && (drop_cnt_q != 16'hFFFF))
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    // Frame FSM; broadcast_drop is registered alongside the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            drop_q <= 1'b0;
        end else if (bus.rx_frame_start) begin
            state  <= FRAME;
            drop_q <= 1'b0;
        end else begin
            unique case (state)
                FRAME: begin
                    if (bus.rx_frame_end) begin
                        state  <= IDLE;
                        drop_q <= 1'b0;
                    end else if (bus.broadcast_ptn) begin
                        state  <= starve ? DROP : PASS;
                        drop_q <= starve;
                    end
                end
                PASS, DROP: begin
                    if (bus.rx_frame_end) begin
                        state  <= IDLE;
                        drop_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    drop_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.broadcast_drop = drop_q;
    assign bus.tokens         = tok_q;
    assign bus.drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_broadcast_bucket_filter.sv
// Bench for broadcast_bucket_filter: directed vector table, corner
// sequences and random traffic against a token-bucket reference model.
module tb_broadcast_bucket_filter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        en;
    logic [15:0] depth;
    logic [15:0] ivl;
    logic        start;
    logic        ptn;
    logic        fend;
    logic        clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    broadcast_bucket_filter_if bus0 ();
    broadcast_bucket_filter_if bus1 ();

    assign bus0.broadcast_filter_en       = en;
    assign bus0.broadcast_bucket_depth    = depth;
    assign bus0.broadcast_bucket_interval = ivl;
    assign bus0.rx_frame_start            = start;
    assign bus0.broadcast_ptn             = ptn;
    assign bus0.rx_frame_end              = fend;
    assign bus0.drop_cnt_clr              = clr;
    assign bus1.broadcast_filter_en       = en;
    assign bus1.broadcast_bucket_depth    = depth;
    assign bus1.broadcast_bucket_interval = ivl;
    assign bus1.rx_frame_start            = start;
    assign bus1.broadcast_ptn             = ptn;
    assign bus1.rx_frame_end              = fend;
    assign bus1.drop_cnt_clr              = clr;

    broadcast_bucket_filter #(
        .PRESCALE   (1),
        .PRESCALE_W (1)
    ) dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus0)
    );

    broadcast_bucket_filter #(
        .PRESCALE   (3),
        .PRESCALE_W (2)
    ) dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus1)
    );

    // Reference model: frame status 0=none 1=unclassified 2=ok 3=condemned
    int PS [2] = '{1, 3};
    int m_cyc   [2];
    int m_since [2];
    int m_tok   [2];
    int m_cnt   [2];
    int m_st    [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cyc[k]   = 0;
            m_since[k] = 0;
            m_tok[k]   = 0;
            m_cnt[k]   = 0;
            m_st[k]    = 0;
        end
    endfunction

    function automatic void model_step();
        bit tick;
        bit refill;
        bit cls;
        int avail;
        for (int k = 0; k < 2; k++) begin
            tick = (m_cyc[k] % PS[k]) == PS[k] - 1;
            m_cyc[k]++;
            refill = 1'b0;
            if (tick) begin
                if (m_since[k] >= int'(ivl)) begin
                    refill     = 1'b1;
                    m_since[k] = 0;
                end else begin
                    m_since[k]++;
                end
            end
            if (refill)
                avail = int'(depth);
            else
                avail = (m_tok[k] < int'(depth)) ? m_tok[k] : int'(depth);
            cls = (m_st[k] == 1) && ptn && !fend && !start;
            if (clr)
                m_cnt[k] = 0;
            else if (cls && en && avail == 0 && m_cnt[k] < 65535)
                m_cnt[k]++;
            if (!en)
                m_tok[k] = int'(depth);
            else if (cls && avail > 0)
                m_tok[k] = avail - 1;
            else
                m_tok[k] = avail;
            if (start)
                m_st[k] = 1;
            else if (m_st[k] != 0 && fend)
                m_st[k] = 0;
            else if (cls)
                m_st[k] = (en && avail == 0) ? 3 : 2;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("m0.drop", int'(bus0.broadcast_drop), int'(m_st[0] == 3));
        check("m0.tokens", int'(bus0.tokens), m_tok[0]);
        check("m0.drop_cnt", int'(bus0.drop_cnt), m_cnt[0]);
        check("m1.drop", int'(bus1.broadcast_drop), int'(m_st[1] == 3));
        check("m1.tokens", int'(bus1.tokens), m_tok[1]);
        check("m1.drop_cnt", int'(bus1.drop_cnt), m_cnt[1]);
    endtask

    // Inputs are changed 1 time unit after the edge, outputs sampled there.
    task automatic cycle(input logic s, input logic p, input logic e);
        start = s;
        ptn   = p;
        fend  = e;
        model_step();
        @(posedge Clk);
        #1;
        check_model();
        start = 1'b0;
        ptn   = 1'b0;
        fend  = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        #1;
        check("rst.drop", int'(bus0.broadcast_drop), 0);
        check("rst.tokens", int'(bus0.tokens), 0);
        check("rst.drop_cnt", int'(bus0.drop_cnt), 0);
        check("rst1.drop_cnt", int'(bus1.drop_cnt), 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    typedef struct {
        logic        s;
        logic        p;
        logic        e;
        logic        en;
        logic        drop;
        logic [15:0] tok;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{s:0, p:0, e:0, en:0, drop:0, tok:3, cnt:0};
        tbl[1]  = '{s:1, p:0, e:0, en:1, drop:0, tok:3, cnt:0};
        tbl[2]  = '{s:0, p:1, e:0, en:1, drop:0, tok:2, cnt:0};
        tbl[3]  = '{s:0, p:0, e:1, en:1, drop:0, tok:2, cnt:0};
        tbl[4]  = '{s:1, p:0, e:0, en:1, drop:0, tok:2, cnt:0};
        tbl[5]  = '{s:0, p:1, e:0, en:1, drop:0, tok:1, cnt:0};
        tbl[6]  = '{s:0, p:0, e:1, en:1, drop:0, tok:1, cnt:0};
        tbl[7]  = '{s:1, p:0, e:0, en:1, drop:0, tok:1, cnt:0};
        tbl[8]  = '{s:0, p:1, e:0, en:1, drop:0, tok:0, cnt:0};
        tbl[9]  = '{s:0, p:0, e:1, en:1, drop:0, tok:0, cnt:0};
        tbl[10] = '{s:1, p:0, e:0, en:1, drop:0, tok:0, cnt:0};
        tbl[11] = '{s:0, p:1, e:0, en:1, drop:1, tok:0, cnt:1};
        tbl[12] = '{s:0, p:0, e:0, en:1, drop:1, tok:0, cnt:1};
        tbl[13] = '{s:0, p:0, e:1, en:1, drop:0, tok:0, cnt:1};

        en    = 1'b0;
        depth = 16'd3;
        ivl   = 16'd99;
        start = 1'b0;
        ptn   = 1'b0;
        fend  = 1'b0;
        clr   = 1'b0;
        Reset = 1'b1;
        #2;
        do_reset();

        // Bucket of 3 drained by four back-to-back broadcast frames.
        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en;
            cycle(tbl[i].s, tbl[i].p, tbl[i].e);
            check($sformatf("t1[%0d].drop", i),
                  int'(bus0.broadcast_drop), int'(tbl[i].drop));
            check($sformatf("t1[%0d].tokens", i),
                  int'(bus0.tokens), int'(tbl[i].tok));
            check($sformatf("t1[%0d].drop_cnt", i),
                  int'(bus0.drop_cnt), int'(tbl[i].cnt));
        end
        for (int t = 15; t <= 100; t++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (t == 99)
                check("t1.before_refill", int'(bus0.tokens), 0);
            if (t == 100)
                check("t1.refill", int'(bus0.tokens), 3);
        end

        // Filter disabled: nothing is ever dropped.
        do_reset();
        en    = 1'b0;
        depth = 16'd0;
        for (int f = 0; f < 5; f++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            check("t2.drop", int'(bus0.broadcast_drop), 0);
            check("t2.tokens", int'(bus0.tokens), int'(depth));
            cycle(1'b0, 1'b0, 1'b1);
        end
        check("t2.drop_cnt", int'(bus0.drop_cnt), 0);

        // Broadcast pattern lands in the refill cycle of an empty bucket.
        do_reset();
        en    = 1'b1;
        depth = 16'd0;
        ivl   = 16'd3;
        cycle(1'b1, 1'b0, 1'b0);
        depth = 16'd2;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("t3.empty", int'(bus0.tokens), 0);
        cycle(1'b0, 1'b1, 1'b0);
        check("t3.tokens", int'(bus0.tokens), 1);
        check("t3.drop", int'(bus0.broadcast_drop), 0);
        cycle(1'b0, 1'b0, 1'b1);

        // Depth lowered below the level, then refill every cycle.
        do_reset();
        ivl   = 16'd500;
        en    = 1'b0;
        depth = 16'd10;
        cycle(1'b0, 1'b0, 1'b0);
        en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
        end
        check("t4.level", int'(bus0.tokens), 8);
        depth = 16'd4;
        cycle(1'b0, 1'b0, 1'b0);
        check("t4.clamp", int'(bus0.tokens), 4);
        ivl   = 16'd0;
        depth = 16'd1;
        for (int f = 0; f < 5; f++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            check("t4.nodrop", int'(bus0.broadcast_drop), 0);
            cycle(1'b0, 1'b0, 1'b1);
        end
        check("t4.drop_cnt", int'(bus0.drop_cnt), 0);

        // Restart out of DROP, then reset in the middle of a DROP.
        do_reset();
        ivl   = 16'd1000;
        en    = 1'b1;
        depth = 16'd0;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("t5.drop", int'(bus0.broadcast_drop), 1);
        cycle(1'b1, 1'b0, 1'b0);
        check("t5.restart", int'(bus0.broadcast_drop), 0);
        cycle(1'b0, 1'b1, 1'b0);
        check("t5.drop2", int'(bus0.broadcast_drop), 1);
        check("t5.cnt2", int'(bus0.drop_cnt), 2);
        #2;
        do_reset();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("t5.ignored", int'(bus0.broadcast_drop), 0);

        // Saturation of the drop counter and clear-over-increment.
        do_reset();
        force dut0.drop_cnt_q = 16'hFFFE;
        #1;
        release dut0.drop_cnt_q;
        m_cnt[0] = 65534;
        for (int f = 0; f < 2; f++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            check("t6.sat", int'(bus0.drop_cnt), 65535);
        end
        cycle(1'b1, 1'b0, 1'b0);
        clr = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        check("t6.clr", int'(bus0.drop_cnt), 0);
        check("t6.drop", int'(bus0.broadcast_drop), 1);

        // Random traffic and configuration churn.
        do_reset();
        en    = 1'b1;
        depth = 16'd2;
        ivl   = 16'd5;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0)
                en = ~en;
            if ($urandom_range(0, 99) == 0)
                depth = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 149) == 0)
                ivl = 16'($urandom_range(0, 20));
            clr = ($urandom_range(0, 99) == 0);
            cycle($urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
